// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - gselect predictor update scheduler
// Sweeps the PHT after reset, then queues resolved branches from two ports and drains one update per cycle.
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req0_target,
  input  logic             req0_taken,
  input  logic             req0_pred_taken,
  input  logic [31:0]      req0_pred_target,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_pc,
  input  logic [31:0]      req1_target,
  input  logic             req1_taken,
  input  logic             req1_pred_taken,
  input  logic [31:0]      req1_pred_target,
  output logic             update,
  output logic [31:0]      branchPC,
  output logic [31:0]      resultPC,
  output logic             taken,
  output logic             mispredict,
  output logic             init_we,
  output logic [IDX_W-1:0] init_idx,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             ptr_q, ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic             update_q, update_d;
  logic             mispredict_q, mispredict_d;
  logic             taken_q, taken_d;
  logic [31:0]      branch_pc_q, branch_pc_d;
  logic [31:0]      result_pc_q, result_pc_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic [31:0] fifo_pc_q     [DEPTH];
  logic [31:0] fifo_tgt_q    [DEPTH];
  logic [31:0] fifo_ptgt_q   [DEPTH];
  logic        fifo_taken_q  [DEPTH];
  logic        fifo_ptaken_q [DEPTH];

  logic        run, full, empty, grant0, grant1, push, pop, head_mp;
  logic [31:0] in_pc, in_tgt, in_ptgt;
  logic        in_taken, in_ptaken;

  always_comb begin
    run    = (state_q == S_RUN);
    full   = (count_q == (AW+1)'(DEPTH));
    empty  = (count_q == '0);
    // Pointer value 0 favours req0 when both ports are valid.
    grant0 = req0_valid & (!req1_valid | !ptr_q);
    grant1 = req1_valid & (!req0_valid |  ptr_q);
    req0_ready = run & !rst & !full & grant0;
    req1_ready = run & !rst & !full & grant1;
    push   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    pop    = run & !empty;

    in_pc     = req1_ready ? req1_pc          : req0_pc;
    in_tgt    = req1_ready ? req1_target      : req0_target;
    in_ptgt   = req1_ready ? req1_pred_target : req0_pred_target;
    in_taken  = req1_ready ? req1_taken       : req0_taken;
    in_ptaken = req1_ready ? req1_pred_taken  : req0_pred_taken;

    head_mp = (fifo_taken_q[rd_q] != fifo_ptaken_q[rd_q]) |
              (fifo_taken_q[rd_q] & (fifo_tgt_q[rd_q] != fifo_ptgt_q[rd_q]));
  end

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    update_d     = 1'b0;
    mispredict_d = 1'b0;
    taken_d      = taken_q;
    branch_pc_d  = branch_pc_q;
    result_pc_d  = result_pc_q;
    mcnt_d       = mcnt_q;

    case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == {IDX_W{1'b1}}) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (push) begin
      wr_d  = wr_q + AW'(1);
      ptr_d = req0_ready ? 1'b1 : 1'b0;
    end

    if (pop) begin
      rd_d         = rd_q + AW'(1);
      update_d     = 1'b1;
      mispredict_d = head_mp;
      taken_d      = fifo_taken_q[rd_q];
      branch_pc_d  = fifo_pc_q[rd_q];
      result_pc_d  = fifo_tgt_q[rd_q];
      if (head_mp && (mcnt_q != {CNT_W{1'b1}})) mcnt_d = mcnt_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      ptr_q        <= 1'b0;
      count_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      update_q     <= 1'b0;
      mispredict_q <= 1'b0;
      taken_q      <= 1'b0;
      branch_pc_q  <= '0;
      result_pc_q  <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      update_q     <= update_d;
      mispredict_q <= mispredict_d;
      taken_q      <= taken_d;
      branch_pc_q  <= branch_pc_d;
      result_pc_q  <= result_pc_d;
      mcnt_q       <= mcnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_q]     <= in_pc;
      fifo_tgt_q[wr_q]    <= in_tgt;
      fifo_ptgt_q[wr_q]   <= in_ptgt;
      fifo_taken_q[wr_q]  <= in_taken;
      fifo_ptaken_q[wr_q] <= in_ptaken;
    end
  end

  assign update         = update_q;
  assign mispredict     = mispredict_q;
  assign taken          = taken_q;
  assign branchPC       = branch_pc_q;
  assign resultPC       = result_pc_q;
  assign init_we        = (state_q == S_INIT) & !rst;
  assign init_idx       = init_idx_q;
  assign busy           = (state_q == S_INIT) | !empty;
  assign mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - directed self-checking bench for bp_update_scheduler
// Second instance uses a 2-bit mispredict counter to exercise saturation.
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] pc0 = '0, tg0 = '0, ptg0 = '0, pc1 = '0, tg1 = '0, ptg1 = '0;
  logic        tk0 = 1'b0, ptk0 = 1'b0, tk1 = 1'b0, ptk1 = 1'b0;

  logic        rdy0, rdy1, upd, tkn, mp, iwe, bsy;
  logic [31:0] bpc, rpc;
  logic [7:0]  iidx;
  logic [15:0] mcnt;
  logic        rdy0_b, rdy1_b, upd_b, tkn_b, mp_b, iwe_b, bsy_b;
  logic [31:0] bpc_b, rpc_b;
  logic [7:0]  iidx_b;
  logic [1:0]  mcnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] pc; logic [31:0] rpc; logic tk; logic mp; int c; } upd_t;
  upd_t got[$];

  bp_update_scheduler u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0), .req0_pc(pc0), .req0_target(tg0),
    .req0_taken(tk0), .req0_pred_taken(ptk0), .req0_pred_target(ptg0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_pc(pc1), .req1_target(tg1),
    .req1_taken(tk1), .req1_pred_taken(ptk1), .req1_pred_target(ptg1),
    .update(upd), .branchPC(bpc), .resultPC(rpc), .taken(tkn), .mispredict(mp),
    .init_we(iwe), .init_idx(iidx), .busy(bsy), .mispredict_cnt(mcnt)
  );

  bp_update_scheduler #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0_b), .req0_pc(pc0), .req0_target(tg0),
    .req0_taken(tk0), .req0_pred_taken(ptk0), .req0_pred_target(ptg0),
    .req1_valid(v1), .req1_ready(rdy1_b), .req1_pc(pc1), .req1_target(tg1),
    .req1_taken(tk1), .req1_pred_taken(ptk1), .req1_pred_target(ptg1),
    .update(upd_b), .branchPC(bpc_b), .resultPC(rpc_b), .taken(tkn_b), .mispredict(mp_b),
    .init_we(iwe_b), .init_idx(iidx_b), .busy(bsy_b), .mispredict_cnt(mcnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && upd) got.push_back('{pc: bpc, rpc: rpc, tk: tkn, mp: mp, c: cyc});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [31:0] pc, input logic [31:0] tg,
                         input logic tk, input logic ptk, input logic [31:0] ptg);
    if (port == 0) begin
      v0 = 1'b1; pc0 = pc; tg0 = tg; tk0 = tk; ptk0 = ptk; ptg0 = ptg;
    end else begin
      v1 = 1'b1; pc1 = pc; tg1 = tg; tk1 = tk; ptk1 = ptk; ptg1 = ptg;
    end
  endtask

  // Presents one request, confirms it is accepted this cycle, returns the push cycle.
  task automatic push_one(input string tag, input int port, input logic [31:0] pc,
                          input logic [31:0] tg, input logic tk, input logic ptk,
                          input logic [31:0] ptg, output int pcyc);
    set_req(port, pc, tg, tk, ptk, ptg);
    #1;
    check(tag, (port == 0) ? rdy0 : rdy1, 1);
    pcyc = cyc;
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Called right after reset release; leaves the bench in the first RUN cycle.
  task automatic init_sweep(input string tag);
    int n = 0;
    int bad = 0;
    check({tag, "_busy"}, bsy, 1);
    while (iwe && n < 300) begin
      if (iidx !== n[7:0] || rdy0 !== 1'b0) bad++;
      n++;
      tick();
    end
    check({tag, "_len"}, n, 256);
    check({tag, "_seq"}, bad, 0);
    check({tag, "_idx_wrap"}, iidx, 0);
  endtask

  initial begin
    int pc_cyc;
    logic [31:0] a0[$];
    logic [31:0] a1[$];
    logic [31:0] acc[$];
    logic [31:0] exp_ord[$];
    int bad;
    int both;
    int n;

    // Reset state
    #2;
    v0 = 1'b1;
    #1;
    check("rst_init_we", iwe, 0);
    check("rst_ready0", rdy0, 0);
    check("rst_update", upd, 0);
    check("rst_bpc", bpc, 0);
    check("rst_cnt", mcnt, 0);
    v0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    init_sweep("init1");

    // First RUN cycle: req0 accepted immediately, update two cycles later
    got.delete();
    push_one("single_rdy", 0, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, pc_cyc);
    check("single_c1_noupd", upd, 0);
    repeat (4) tick();
    check("single_n", got.size(), 1);
    if (got.size() == 1) begin
      check("single_lat", got[0].c, pc_cyc + 2);
      check("single_bpc", got[0].pc, 32'h100);
      check("single_rpc", got[0].rpc, 32'h200);
      check("single_tk", got[0].tk, 1);
      check("single_mp", got[0].mp, 0);
    end
    check("single_cnt", mcnt, 0);
    check("idle_busy", bsy, 0);
    check("idle_upd", upd, 0);
    check("hold_bpc", bpc, 32'h100);

    // Target mispredict on taken branch, then direction mispredict
    got.delete();
    push_one("mp_tgt_rdy", 1, 32'h110, 32'h300, 1'b1, 1'b1, 32'h200, pc_cyc);
    push_one("mp_dir_rdy", 1, 32'h120, 32'h124, 1'b0, 1'b1, 32'h400, pc_cyc);
    repeat (4) tick();
    check("mp_n", got.size(), 2);
    if (got.size() == 2) begin
      check("mp_tgt", got[0].mp, 1);
      check("mp_dir", got[1].mp, 1);
      check("mp_dir_tk", got[1].tk, 0);
    end
    check("mp_cnt2", mcnt, 2);
    check("mp_cnt2_sat", mcnt_b, 2);

    // Both requesters streaming: pointer favours req0 after the last req1 push
    for (int i = 0; i < 4; i++) begin
      a0.push_back(32'h1000 + 32'(i) * 4);
      a1.push_back(32'h2000 + 32'(i) * 4);
      exp_ord.push_back(32'h1000 + 32'(i) * 4);
      exp_ord.push_back(32'h2000 + 32'(i) * 4);
    end
    got.delete();
    both = 0;
    n = 0;
    while ((a0.size() > 0 || a1.size() > 0) && n < 40) begin
      v0 = 1'b0;
      v1 = 1'b0;
      if (a0.size() > 0) set_req(0, a0[0], a0[0] + 32'h40, 1'b1, 1'b1, a0[0] + 32'h40);
      if (a1.size() > 0) set_req(1, a1[0], a1[0] + 32'h40, 1'b1, 1'b1, a1[0] + 32'h40);
      #1;
      if (rdy0 && rdy1) both++;
      if (v0 && rdy0) acc.push_back(a0.pop_front());
      else if (v1 && rdy1) acc.push_back(a1.pop_front());
      n++;
      tick();
    end
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (4) tick();
    check("arb_cycles", n, 8);
    check("arb_both_ready", both, 0);
    check("arb_acc_n", acc.size(), 8);
    check("arb_upd_n", got.size(), 8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= acc.size() || acc[i] !== exp_ord[i]) bad++;
      if (i >= got.size() || got[i].pc !== exp_ord[i] || got[i].rpc !== exp_ord[i] + 32'h40 ||
          got[i].mp !== 1'b0 || got[i].c !== got[0].c + i) bad++;
    end
    check("arb_order", bad, 0);
    check("arb_cnt", mcnt, 2);

    // Not-taken with differing target is not a mispredict; two more real ones saturate the 2-bit count
    got.delete();
    push_one("nt_rdy", 0, 32'h500, 32'h504, 1'b0, 1'b0, 32'h900, pc_cyc);
    push_one("m3_rdy", 0, 32'h510, 32'h600, 1'b1, 1'b0, 32'h600, pc_cyc);
    push_one("m4_rdy", 1, 32'h520, 32'h524, 1'b0, 1'b1, 32'h700, pc_cyc);
    repeat (4) tick();
    check("sat_n", got.size(), 3);
    if (got.size() == 3) begin
      check("nt_mp", got[0].mp, 0);
      check("m3_mp", got[1].mp, 1);
    end
    check("cnt16_4", mcnt, 4);
    check("cnt2_sat", mcnt_b, 3);

    // Reset while updates are in flight
    set_req(0, 32'h3000, 32'h3100, 1'b1, 1'b1, 32'h3100);
    tick();
    pc0 = 32'h3004;
    tick();
    check("pre_rst_upd", upd, 1);
    rst = 1'b1;
    #1;
    check("arst_upd", upd, 0);
    check("arst_bpc", bpc, 0);
    check("arst_rpc", rpc, 0);
    check("arst_tk", tkn, 0);
    check("arst_cnt", mcnt, 0);
    check("arst_we", iwe, 0);
    check("arst_rdy", rdy0, 0);
    got.delete();
    repeat (3) tick();
    v0 = 1'b0;
    rst = 1'b0;
    #1;
    init_sweep("init2");
    check("post_rst_noupd", got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sequences all writes into the gselect branch predictor (GHR, PHT set, direct-mapped BTB).
- After reset it runs a PHT initialisation sweep. It then arbitrates resolved-branch reports from two execute-stage requesters into a small FIFO.
- It drains the FIFO at one predictor update per cycle and flags and counts mispredictions.
- Sits between the execute stages and the predictor's update/branchPC/resultPC/taken inputs.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
IDX_W, 8, PHT index width; init sweep covers 2^IDX_W entries
CNT_W, 16, mispredict counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
reqN_valid  input  1  requester N (N=0,1) has a resolved branch
reqN_ready  output  1  requester N accepted this cycle when valid&ready
reqN_pc  input  32  branch PC
reqN_target  input  32  resolved target PC
reqN_taken  input  1  resolved direction
reqN_pred_taken  input  1  direction predicted at fetch
reqN_pred_target  input  32  target predicted at fetch
update  output  1  one-cycle predictor update strobe
branchPC  output  32  PC for update
resultPC  output  32  resolved target for update
taken  output  1  resolved direction for update
mispredict  output  1  high with update when the entry was mispredicted
init_we  output  1  PHT clear strobe during init sweep
init_idx  output  IDX_W  PHT index being cleared
busy  output  1  high in INIT or while FIFO non-empty
mispredict_cnt  output  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, any time, including mid-sweep or mid-drain) clears these:
  - update, mispredict, taken, branchPC, resultPC, init_idx and mispredict_cnt go to 0.
  - FIFO becomes empty and the priority pointer points to req0.
  - State goes to INIT.
  - While rst is high, init_we=0 and reqN_ready=0.
- State INIT:
  - init_we=1 every cycle; init_idx increments 0..2^IDX_W-1.
  - reqN_ready=0 and no FIFO pops.
  - On the edge where init_idx=2^IDX_W-1, go to RUN. init_idx wraps to 0 and init_we drops.
  - The sweep lasts exactly 2^IDX_W cycles (256 by default).
- State RUN: stays in RUN until reset.
- Arbitration (combinational, RUN only): at most one push per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the priority-pointer side is granted.
  - reqN_ready = RUN & !full & grantN. The ungranted requester sees ready=0 and must hold its payload.
  - After any accepted push from port N, the pointer moves to the other port.
- FIFO:
  - Circular, DEPTH entries. Each entry holds pc, target, taken, pred_taken, pred_target.
  - full and empty are derived from a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - There is no input-to-output bypass.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, ready stays low even if a pop occurs that cycle.
- Drain:
  - In RUN, when the FIFO is non-empty, pop the head each cycle.
  - On that edge the output registers load update=1, branchPC=pc, resultPC=target and taken.
  - mispredict = (taken != pred_taken) | (taken & (target != pred_target)).
  - When the FIFO is empty, update=0 and mispredict=0; branchPC, resultPC and taken hold their last values.
- Latency: a handshake in cycle c puts update high in cycle c+2 when the FIFO was empty. With back-to-back pushes, one update per cycle.
- mispredict_cnt:
  - Increments on each popped entry that has mispredict=1.
  - Saturates at 2^CNT_W-1; no wrap.
- busy = (state==INIT) | !empty.

Test Plan:
- Release reset -> init_we high for exactly 256 cycles, init_idx 0..255. In cycle 257, init_we=0 and req0_ready=1 with req0_valid=1.
- RUN, single push req0 {pc=0x100, target=0x200, taken=1, pred_taken=1, pred_target=0x200} in cycle c -> update=1 in cycle c+2 only, branchPC=0x100, resultPC=0x200, mispredict=0, count stays 0.
- Both requesters valid for 4 cycles, different PCs -> acceptance order req0,req1,req0,req1 and updates emitted in the same order on consecutive cycles.
- Hold both requesters valid with the FIFO drain pushed to full (DEPTH=4): verify ready=0 when count=4 even on a pop cycle, no entry lost or duplicated, and all updates delivered in order.
- Mispredict cases: taken=0 with pred_taken=1 -> mispredict=1; taken=1, pred_taken=1 with target 0x300 vs pred_target 0x200 -> mispredict=1. Count reaches 2; with CNT_W=2 forced, the count saturates at 3.
- Assert rst mid-drain with 3 entries queued -> outputs clear immediately, no further update pulses, and a new 256-cycle INIT sweep starts on release.
